// File: rtl/sevenseg_pkg.sv
// Shared definitions for the 4-digit seven-segment scan controller.
// Holds the blank/off pin levels, active-low hex glyphs (bit 6 = a ... bit 0 = g)
// and the scan state enumeration.
package sevenseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  localparam logic [6:0] GLYPH_0 = 7'h01;
  localparam logic [6:0] GLYPH_1 = 7'h4F;
  localparam logic [6:0] GLYPH_2 = 7'h12;
  localparam logic [6:0] GLYPH_3 = 7'h06;
  localparam logic [6:0] GLYPH_4 = 7'h4C;
  localparam logic [6:0] GLYPH_5 = 7'h24;
  localparam logic [6:0] GLYPH_6 = 7'h20;
  localparam logic [6:0] GLYPH_7 = 7'h0F;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h04;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h60;
  localparam logic [6:0] GLYPH_C = 7'h31;
  localparam logic [6:0] GLYPH_D = 7'h42;
  localparam logic [6:0] GLYPH_E = 7'h30;
  localparam logic [6:0] GLYPH_F = 7'h38;

  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex nibble to active-low seven-segment glyph.
// Ports:
//   nibble  in  4  hex digit to decode
//   seg     out 7  segments a..g (bit 6 = a), active low
module hex_seg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = GLYPH_A;
      4'hB: seg = GLYPH_B;
      4'hC: seg = GLYPH_C;
      4'hD: seg = GLYPH_D;
      4'hE: seg = GLYPH_E;
      4'hF: seg = GLYPH_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan of a 16-bit hex value onto a 4-digit common-anode
// display, with a double-buffered value (swapped only at the frame boundary)
// and an all-anodes-off guard gap at the start of every digit slot.
// Ports:
//   clk         in  1   clock
//   rst         in  1   synchronous active-high reset
//   value_in    in  16  value to show, nibble k on digit k (digit 0 rightmost)
//   dp_in       in  4   decimal point enables, captured with value_in
//   load        in  1   capture strobe into the shadow register
//   seg         out 7   segments a..g, active low, registered
//   dp          out 1   decimal point, active low, registered
//   an          out 4   digit enables, active low, registered
//   frame_tick  out 1   one-cycle pulse at the end of digit 3's slot
//   pending     out 1   shadow holds a value not yet applied
//
// state | meaning
// GUARD | first GUARD_CYC cycles of a slot, all anodes off
// SHOW  | rest of the slot, digit idx driven (unless leading-zero blanked)
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 16,
  parameter int BLANK_LZ    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_tick,
  output logic        pending
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_END = CW'(GUARD_CYC);

  scan_state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [1:0]    idx, idx_next;
  logic          boundary;

  logic [15:0] shadow_val, active_val;
  logic [3:0]  shadow_dp, active_dp;

  logic [3:0]  nibble;
  logic [6:0]  glyph;
  logic [3:0]  lz_blank;
  logic        digit_blank;

  logic [6:0]  seg_d;
  logic        dp_d;
  logic [3:0]  an_d;

  // Scan state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= GUARD;
      cnt   <= '0;
      idx   <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
    end
  end

  // Next-state: the state is a pure function of the slot position
  always_comb begin
    cnt_next = cnt + 1'b1;
    idx_next = idx;
    boundary = 1'b0;
    if (cnt == CNT_LAST) begin
      cnt_next = '0;
      idx_next = idx + 2'd1;
      boundary = (idx == 2'd3);
    end
    state_next = (cnt_next < GUARD_END) ? GUARD : SHOW;
  end

  // Double buffer. A load on the boundary cycle goes straight to active so
  // it is not deferred a whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
    end else begin
      if (load) begin
        shadow_val <= value_in;
        shadow_dp  <= dp_in;
      end
      if (boundary) begin
        if (load) begin
          active_val <= value_in;
          active_dp  <= dp_in;
        end else if (pending) begin
          active_val <= shadow_val;
          active_dp  <= shadow_dp;
        end
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  assign nibble = active_val[{idx, 2'b00} +: 4];

  hex_seg_decode u_dec (
    .nibble (nibble),
    .seg    (glyph)
  );

  // lz_blank[k]: every nibble from k up to 3 is zero; digit 0 always shown
  always_comb begin
    lz_blank[3] = (active_val[15:12] == 4'h0);
    lz_blank[2] = lz_blank[3] && (active_val[11:8] == 4'h0);
    lz_blank[1] = lz_blank[2] && (active_val[7:4] == 4'h0);
    lz_blank[0] = 1'b0;
    digit_blank = (BLANK_LZ != 0) && lz_blank[idx];
  end

  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    an_d  = AN_OFF;
    if (state == SHOW && !digit_blank) begin
      seg_d = glyph;
      dp_d  = ~active_dp[idx];
      an_d  = ~(4'b0001 << idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      an         <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_d;
      dp         <= dp_d;
      an         <= an_d;
      frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl with an 8-cycle slot and 2-cycle guard.
// A time-based reference model pushes the expected pins for every clock into
// a queue; a monitor on the falling edge pops and compares.
module tb_sevenseg_scan_ctrl;

  localparam int RD    = 8;
  localparam int GC    = 2;
  localparam int FRAME = 4 * RD;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;
  logic        pending;

  sevenseg_scan_ctrl #(
    .REFRESH_DIV (RD),
    .GUARD_CYC   (GC),
    .BLANK_LZ    (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .load       (load),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
    logic       pend;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state: cycles since reset and the buffered values
  int          t = 0;
  logic [15:0] m_act, m_sh;
  logic [3:0]  m_adp, m_sdp;
  logic        m_pend;

  // Glyph built from the lit segment letters
  function automatic logic [6:0] glyph(input logic [3:0] n);
    string s;
    logic [6:0] g;
    case (n)
      4'h0: s = "abcdef";
      4'h1: s = "bc";
      4'h2: s = "abdeg";
      4'h3: s = "abcdg";
      4'h4: s = "bcfg";
      4'h5: s = "acdfg";
      4'h6: s = "acdefg";
      4'h7: s = "abc";
      4'h8: s = "abcdefg";
      4'h9: s = "abcdfg";
      4'hA: s = "abcefg";
      4'hB: s = "cdefg";
      4'hC: s = "adef";
      4'hD: s = "bcdeg";
      4'hE: s = "adefg";
      default: s = "aefg";
    endcase
    g = 7'h7F;
    for (int i = 0; i < s.len(); i++) g[6 - (s[i] - "a")] = 1'b0;
    return g;
  endfunction

  // Reference model: one expected pin set per rising edge
  initial begin
    exp_t e;
    int pos, dig;
    logic brd;
    forever begin
      @(posedge clk);
      if (rst) begin
        t = 0; m_act = '0; m_sh = '0; m_adp = '0; m_sdp = '0; m_pend = 1'b0;
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.ft = 1'b0; e.pend = 1'b0;
      end else begin
        pos = t % RD;
        dig = (t / RD) % 4;
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
        if (pos >= GC && !(dig != 0 && (m_act >> (4 * dig)) == 0)) begin
          e.an  = 4'hF & ~(4'(1) << dig);
          e.seg = glyph(4'((m_act >> (4 * dig)) & 16'hF));
          e.dp  = ~m_adp[dig];
        end
        brd = (pos == RD - 1) && (dig == 3);
        e.ft = brd;
        if (brd) begin
          if (load) begin m_act = value_in; m_adp = dp_in; end
          else if (m_pend) begin m_act = m_sh; m_adp = m_sdp; end
          m_pend = 1'b0;
        end else if (load) begin
          m_sh = value_in; m_sdp = dp_in; m_pend = 1'b1;
        end
        e.pend = m_pend;
        t++;
      end
      exp_q.push_back(e);
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, want);
    end
  endtask

  // Monitor: compare pins, plus anode safety checked every cycle
  initial begin
    exp_t e;
    logic [3:0] prev_an;
    int off_run;
    prev_an = 4'hF;
    off_run = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("an", 16'(an), 16'(e.an));
        chk("seg", 16'(seg), 16'(e.seg));
        chk("dp", 16'(dp), 16'(e.dp));
        chk("frame_tick", 16'(frame_tick), 16'(e.ft));
        chk("pending", 16'(pending), 16'(e.pend));
        chk("an_onehot_low", 16'($countones(~an) <= 1), 16'd1);
        if (an != 4'hF) begin
          if (prev_an == 4'hF) chk("guard_gap", 16'(off_run >= GC), 16'd1);
          else chk("an_switch_no_gap", 16'(an), 16'(prev_an));
          off_run = 0;
        end else begin
          off_run++;
        end
        prev_an = an;
      end
    end
  end

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load = 1'b1; value_in = v; dp_in = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  // At a falling edge, t is the frame position the next rising edge sees
  task automatic wait_pos(input int p);
    for (int i = 0; i < 2 * FRAME && (t % FRAME) != p; i++) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value_in = '0; dp_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * FRAME) @(negedge clk);

    wait_pos(13);
    do_load(16'h1A3F, 4'b0100);
    repeat (2 * FRAME + 5) @(negedge clk);

    wait_pos(3);
    do_load(16'h1234, 4'b1111);
    wait_pos(20);
    do_load(16'h0005, 4'b0000);
    repeat (2 * FRAME) @(negedge clk);

    wait_pos(31);
    do_load(16'hBEEF, 4'b1001);
    repeat (FRAME + 8) @(negedge clk);

    wait_pos(5);
    do_load(16'h4321, 4'b0010);
    wait_pos(20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (FRAME + 8) @(negedge clk);

    for (int i = 0; i < 20 * FRAME; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        load     = 1'b1;
        value_in = 16'($urandom) >> (4 * $urandom_range(0, 3));
        dp_in    = 4'($urandom);
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    repeat (FRAME + 2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
